// File: rtl/osd_dem_uart_16550_fifo.sv
// 16550 register-compatible debug UART with TX/RX FIFOs, valid/ready byte streams and interrupt.
// Optional internal loopback (MCR[4]) is built when OSD_DEM_UART_LOOPBACK_EN is defined.
module osd_dem_uart_16550_fifo #(
  parameter int unsigned TX_DEPTH = 16,
  parameter int unsigned RX_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bus_req,
  input  logic [2:0] bus_addr,
  input  logic       bus_write,
  input  logic [7:0] bus_wdata,
  output logic       bus_ack,
  output logic [7:0] bus_rdata,
  output logic       irq,
  output logic       out_valid,
  output logic [7:0] out_char,
  input  logic       out_ready,
  input  logic       in_valid,
  input  logic [7:0] in_char,
  output logic       in_ready
);

  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned TX_CW = TX_AW + 1;
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned RX_CW = RX_AW + 1;

  logic [7:0]       r_tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] r_tx_wp, r_tx_rp;
  logic [TX_CW-1:0] r_tx_cnt;
  logic [7:0]       r_rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] r_rx_wp, r_rx_rp;
  logic [RX_CW-1:0] r_rx_cnt;

  logic [7:0] r_lcr, r_dll, r_dlm, r_scr;
  logic [4:0] r_mcr;
  logic [1:0] r_ier;
  logic       r_fifo_en, r_thre, r_irq;

  logic       w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic       w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic       w_tx_flush, w_rx_flush;
  logic       w_thr_wr, w_rbr_rd, w_iir_rd, w_ier_wr, w_wr_en;
  logic       w_thre_set, w_thre_clr;
  logic [7:0] w_tx_head, w_rx_head, w_rx_wdata, w_lsr, w_iir;
  logic [3:0] w_iir_id;

  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_full  = (r_tx_cnt == TX_CW'(TX_DEPTH));
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == RX_CW'(RX_DEPTH));
  assign w_tx_head  = r_tx_mem[r_tx_rp];
  assign w_rx_head  = r_rx_mem[r_rx_rp];

  // Only a THR write into a full TX FIFO stalls; the full flag is this cycle's, not look-ahead.
  assign w_thr_wr = bus_req & bus_write & (bus_addr == 3'd0) & ~r_lcr[7];
  assign bus_ack  = ~(w_thr_wr & w_tx_full);
  assign w_wr_en  = bus_req & bus_write & bus_ack;

  assign w_tx_push  = w_thr_wr & ~w_tx_full;
  assign w_rbr_rd   = bus_req & ~bus_write & (bus_addr == 3'd0) & ~r_lcr[7];
  assign w_rx_pop   = w_rbr_rd & ~w_rx_empty;
  assign w_iir_rd   = bus_req & ~bus_write & (bus_addr == 3'd2);
  assign w_ier_wr   = w_wr_en & (bus_addr == 3'd1) & ~r_lcr[7];
  assign w_tx_flush = w_wr_en & (bus_addr == 3'd2) & bus_wdata[2];
  assign w_rx_flush = w_wr_en & (bus_addr == 3'd2) & bus_wdata[1];

`ifdef OSD_DEM_UART_LOOPBACK_EN
  logic w_lb;
  assign w_lb       = r_mcr[4];
  assign w_tx_pop   = w_lb ? (~w_tx_empty & ~w_rx_full) : (out_valid & out_ready);
  assign w_rx_push  = w_lb ? w_tx_pop : (in_valid & in_ready);
  assign w_rx_wdata = w_lb ? w_tx_head : in_char;
  assign out_valid  = ~w_tx_empty & ~w_lb;
  assign in_ready   = ~w_rx_full & ~w_lb;
`else
  assign w_tx_pop   = out_valid & out_ready;
  assign w_rx_push  = in_valid & in_ready;
  assign w_rx_wdata = in_char;
  assign out_valid  = ~w_tx_empty;
  assign in_ready   = ~w_rx_full;
`endif
  assign out_char = w_tx_head;

  assign w_lsr = {1'b0, w_tx_empty, w_tx_empty, 4'b0000, ~w_rx_empty};

  always_comb begin
    w_iir_id = 4'h1;
    if (r_ier[0] & ~w_rx_empty)  w_iir_id = 4'h4;
    else if (r_ier[1] & r_thre)  w_iir_id = 4'h2;
  end
  assign w_iir = {(r_fifo_en ? 2'b11 : 2'b00), 2'b00, w_iir_id};

  always_comb begin
    bus_rdata = 8'h00;
    case (bus_addr)
      3'd0:    bus_rdata = r_lcr[7] ? r_dll : (w_rx_empty ? 8'h00 : w_rx_head);
      3'd1:    bus_rdata = r_lcr[7] ? r_dlm : {6'b0, r_ier};
      3'd2:    bus_rdata = w_iir;
      3'd3:    bus_rdata = r_lcr;
      3'd4:    bus_rdata = {3'b000, r_mcr};
      3'd5:    bus_rdata = w_lsr;
      3'd6:    bus_rdata = 8'hB0;
      default: bus_rdata = r_scr;
    endcase
  end

  // A pop that drains the last entry (no refill, no flush) arms the THR-empty interrupt.
  assign w_thre_set = (w_tx_pop & ~w_tx_push & ~w_tx_flush & (r_tx_cnt == TX_CW'(1)))
                    | (w_ier_wr & bus_wdata[1] & w_tx_empty);
  assign w_thre_clr = w_tx_push | (w_iir_rd & (w_iir_id == 4'h2));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lcr     <= '0;
      r_dll     <= '0;
      r_dlm     <= '0;
      r_scr     <= '0;
      r_mcr     <= '0;
      r_ier     <= '0;
      r_fifo_en <= 1'b0;
      r_thre    <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_irq <= ~w_iir_id[0];
      if (w_thre_set)      r_thre <= 1'b1;
      else if (w_thre_clr) r_thre <= 1'b0;
      if (w_wr_en) begin
        case (bus_addr)
          3'd0:    if (r_lcr[7]) r_dll <= bus_wdata;
          3'd1:    if (r_lcr[7]) r_dlm <= bus_wdata;
                   else          r_ier <= bus_wdata[1:0];
          3'd2:    r_fifo_en <= bus_wdata[0];
          3'd3:    r_lcr <= bus_wdata;
          3'd4:    r_mcr <= bus_wdata[4:0];
          3'd7:    r_scr <= bus_wdata;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= bus_wdata;
    if (w_rx_push) r_rx_mem[r_rx_wp] <= w_rx_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || w_tx_flush) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + TX_AW'(1);
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + TX_AW'(1);
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + TX_CW'(1);
        2'b01:   r_tx_cnt <= r_tx_cnt - TX_CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_rx_flush) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + RX_AW'(1);
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + RX_AW'(1);
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + RX_CW'(1);
        2'b01:   r_rx_cnt <= r_rx_cnt - RX_CW'(1);
        default: ;
      endcase
    end
  end

  assign irq = r_irq;

endmodule

// File: tb/tb_osd_dem_uart_16550_fifo.sv
// Directed self-checking bench for osd_dem_uart_16550_fifo (default depths, loopback disabled).
module tb_osd_dem_uart_16550_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bus_req = 1'b0;
  logic [2:0] bus_addr = '0;
  logic       bus_write = 1'b0;
  logic [7:0] bus_wdata = '0;
  logic       bus_ack;
  logic [7:0] bus_rdata;
  logic       irq;
  logic       out_valid;
  logic [7:0] out_char;
  logic       out_ready = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_char = '0;
  logic       in_ready;

  int checks = 0;
  int errors = 0;
  logic [7:0] rd_v;

  osd_dem_uart_16550_fifo #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .bus_req(bus_req), .bus_addr(bus_addr), .bus_write(bus_write),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .irq(irq),
    .out_valid(out_valid), .out_char(out_char), .out_ready(out_ready),
    .in_valid(in_valid), .in_char(in_char), .in_ready(in_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  // Holds the request until acknowledged (bounded), commits on the next rising edge.
  task automatic acc(input logic wr, input logic [2:0] a, input logic [7:0] d,
                     output logic [7:0] rdat);
    int n;
    @(negedge clk);
    bus_req = 1'b1; bus_write = wr; bus_addr = a; bus_wdata = d;
    #1;
    n = 0;
    while (!bus_ack && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (!bus_ack) chk("ack_timeout", 8'(bus_ack), 8'h01);
    rdat = bus_rdata;
    @(posedge clk); #1;
    bus_req = 1'b0; bus_write = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    logic [7:0] dummy;
    acc(1'b1, a, d, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] v;
    acc(1'b0, a, 8'h00, v);
    chk(tag, v, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // Reset state
    rd_chk("rst_lsr", 3'd5, 8'h60);
    rd_chk("rst_iir", 3'd2, 8'h01);
    chk("rst_irq", 8'(irq), 8'h00);
    chk("rst_in_ready", 8'(in_ready), 8'h01);
    chk("rst_out_valid", 8'(out_valid), 8'h00);

    // Basic TX
    wr(3'd0, 8'h41);
    chk("tx_valid", 8'(out_valid), 8'h01);
    chk("tx_head", out_char, 8'h41);
    wr(3'd0, 8'h42);
    @(negedge clk); out_ready = 1'b1; #1;
    chk("tx_char0", out_char, 8'h41);
    @(negedge clk); #1;
    chk("tx_char1", out_char, 8'h42);
    @(negedge clk); out_ready = 1'b0; #1;
    chk("tx_drained", 8'(out_valid), 8'h00);
    rd_chk("tx_lsr", 3'd5, 8'h60);

    // TX full stall
    for (int i = 0; i < 16; i++) wr(3'd0, 8'(8'h80 + i));
    rd_chk("full_lsr", 3'd5, 8'h00);
    @(negedge clk);
    bus_req = 1'b1; bus_write = 1'b1; bus_addr = 3'd0; bus_wdata = 8'h90; #1;
    chk("full_stall", 8'(bus_ack), 8'h00);
    @(negedge clk); out_ready = 1'b1; #1;
    chk("full_pop_same_cycle", 8'(bus_ack), 8'h00);
    @(negedge clk); out_ready = 1'b0; #1;
    chk("full_ack_after", 8'(bus_ack), 8'h01);
    @(posedge clk); #1; bus_req = 1'b0; bus_write = 1'b0;
    @(negedge clk); out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("full_order_v", 8'(out_valid), 8'h01);
      chk("full_order", out_char, (i == 15) ? 8'h90 : 8'(8'h81 + i));
      @(negedge clk);
    end
    out_ready = 1'b0; #1;
    chk("full_empty", 8'(out_valid), 8'h00);

    // RX fill and drain with RX interrupt
    wr(3'd1, 8'h01);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); in_valid = 1'b1; in_char = 8'(8'h10 + i);
    end
    @(negedge clk); in_valid = 1'b0; #1;
    chk("rx_full_ready", 8'(in_ready), 8'h00);
    rd_chk("rx_lsr", 3'd5, 8'h61);
    rd_chk("rx_iir", 3'd2, 8'h04);
    chk("rx_irq", 8'(irq), 8'h01);
    for (int i = 0; i < 16; i++) rd_chk("rx_data", 3'd0, 8'(8'h10 + i));
    rd_chk("rx_lsr_empty", 3'd5, 8'h60);
    chk("rx_irq_clr", 8'(irq), 8'h00);
    rd_chk("rx_rbr_empty", 3'd0, 8'h00);

    // THRE interrupt
    wr(3'd1, 8'h02);
    rd_chk("thre_iir", 3'd2, 8'h02);
    chk("thre_irq", 8'(irq), 8'h01);
    rd_chk("thre_iir_clr", 3'd2, 8'h01);
    chk("thre_irq_clr", 8'(irq), 8'h00);
    wr(3'd0, 8'h33);
    rd_chk("thre_after_wr", 3'd2, 8'h01);
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    rd_chk("thre_rearm", 3'd2, 8'h02);
    chk("thre_rearm_irq", 8'(irq), 8'h01);
    rd_chk("thre_rearm_clr", 3'd2, 8'h01);

    // DLAB
    wr(3'd3, 8'h80);
    wr(3'd0, 8'h55);
    chk("dlab_no_tx", 8'(out_valid), 8'h00);
    rd_chk("dll", 3'd0, 8'h55);
    wr(3'd1, 8'hAA);
    rd_chk("dlm", 3'd1, 8'hAA);
    wr(3'd3, 8'h03);
    rd_chk("lcr", 3'd3, 8'h03);
    rd_chk("ier", 3'd1, 8'h02);
    wr(3'd0, 8'h66);
    chk("thr_again", out_char, 8'h66);

    // FCR flush
    @(negedge clk); in_valid = 1'b1; in_char = 8'h77;
    @(negedge clk); in_valid = 1'b0;
    rd_chk("pre_flush_lsr", 3'd5, 8'h01);
    wr(3'd2, 8'h07);
    chk("flush_tx", 8'(out_valid), 8'h00);
    chk("flush_rx_ready", 8'(in_ready), 8'h01);
    rd_chk("flush_lsr", 3'd5, 8'h60);
    rd_chk("flush_iir", 3'd2, 8'hC1);

    // Storage registers
    wr(3'd7, 8'h5A);
    rd_chk("scr", 3'd7, 8'h5A);
    rd_chk("msr", 3'd6, 8'hB0);
    wr(3'd4, 8'hFF);
    rd_chk("mcr", 3'd4, 8'h1F);

    // Mid-operation reset
    wr(3'd0, 8'h12);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    chk("rst2_out_valid", 8'(out_valid), 8'h00);
    rd_chk("rst2_lcr", 3'd3, 8'h00);
    rd_chk("rst2_scr", 3'd7, 8'h00);
    rd_chk("rst2_iir", 3'd2, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/osd_dem_uart_16550_fifo.md
Name: osd_dem_uart_16550_fifo

Overview:
- Next-generation 16550 register-compatible UART emulation for the debug UART device-emulation module.
- Adds parametrised TX/RX FIFOs and a real receive path (RBR, LSR.DR), plus IER/IIR/FCR/SCR registers and an interrupt output.
- Byte streams to and from the debug interconnect use valid/ready on out_*/in_*.
- The CPU bus side keeps the existing req/ack single-cycle register interface.

Parameters:
- TX_DEPTH, 16, TX FIFO entries (power of 2, >=2)
- RX_DEPTH, 16, RX FIFO entries (power of 2, >=2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- bus_req  in  1  register access request
- bus_addr  in  3  register index
- bus_write  in  1  1=write, 0=read
- bus_wdata  in  8  write data
- bus_ack  out  1  access completes this cycle (combinational)
- bus_rdata  out  8  read data (combinational, valid when bus_ack)
- irq  out  1  interrupt, active-high, registered
- out_valid  out  1  TX byte available
- out_char  out  8  TX byte (TX FIFO head)
- out_ready  in  1  consumer accepts TX byte
- in_valid  in  1  RX byte offered
- in_char  in  8  RX byte
- in_ready  out  1  RX FIFO can accept

Interface: Reset rst, synchronous, active-high; clock clk.

Behaviour:
- Register map. DLAB = LCR[7].
  - 0: read RBR, write THR; DLL when DLAB=1.
  - 1: IER[1:0]; DLM when DLAB=1.
  - 2: read IIR, write FCR.
  - 3: LCR.
  - 4: MCR.
  - 5: LSR (read-only).
  - 6: MSR, reads 0xB0.
  - 7: SCR.
- Plain storage: DLL, DLM, LCR, MCR[4:0] and SCR are read/write storage only. No baud timing.
- Reset values: LCR=0, IER=0, DLL=0, DLM=0, SCR=0, MCR=0, FCR-enable=0, both FIFOs empty, thre_pending=0, irq=0, out_valid=0, in_ready=1.
- bus_ack = 1 for every access, except a THR write (addr 0, DLAB=0) while the TX FIFO is full. That write stalls with bus_ack=0 until space exists.
- Side effects (THR push, RBR pop, IIR read clearing) occur only in a cycle with bus_req & bus_ack.
- THR write pushes bus_wdata into the TX FIFO.
  - out_valid = TX FIFO non-empty; out_char = head.
  - Pop on out_valid & out_ready.
  - Write in cycle N gives out_valid=1 in cycle N+1 (FIFO was empty).
- TX full with a simultaneous pop: the write stalls that cycle (ack uses full flag from the current cycle, not look-ahead).
- RX path:
  - in_ready = RX FIFO not full; push on in_valid & in_ready.
  - RBR read returns the RX head and pops it.
  - RBR read when RX empty returns 0x00, no pop.
- Simultaneous push and pop on either FIFO: count unchanged, both take effect.
- Pointers wrap modulo depth. Count is log2(DEPTH)+1 bits.
- FCR write:
  - bit0 is stored as fifo_en.
  - bit1 flushes RX FIFO; bit2 flushes TX FIFO, same cycle, overriding a concurrent push/pop on that FIFO.
  - Bits are self-clearing.
- LSR = {1'b0, TEMT, THRE, 4'b0, DR}.
  - DR = RX non-empty.
  - THRE = TX empty.
  - TEMT = TX empty (no shift register exists, so TEMT equals THRE).
- thre_pending:
  - Set on the cycle the TX FIFO becomes empty via pop.
  - Set on an IER write that sets IER[1] while TX is empty.
  - Cleared by a THR write, or by an IIR read reporting 0x2.
- IIR[3:0], by priority:
  - IER[0] & DR → 0x4.
  - Else IER[1] & thre_pending → 0x2.
  - Else 0x1.
- IIR[7:6] = 2'b11 when fifo_en, else 00.
- irq is registered from the combinational IIR[0]==0, so one cycle latency.
- rst asserted mid-operation: all state returns to reset values next edge. In-flight FIFO contents are discarded.

Optional Feature:
- Macro OSD_DEM_UART_LOOPBACK_EN.
- Defined:
  - When MCR[4]=1, TX FIFO head feeds the RX FIFO internally (pop when RX not full).
  - out_valid forced 0.
  - in_ready forced 0.
  - MCR[4]=0 behaves normally.
- Undefined: MCR[4] is storage only, no loopback logic is generated.

Test Plan:
- Reset then read addr 5 → 0x60. Read addr 2 → 0x01. irq=0. in_ready=1.
- THR writes 0x41,0x42 with out_ready=0 → out_valid=1 from next cycle, out_char=0x41. out_ready=1 two cycles → 0x41, 0x42 emitted in order. LSR returns 0x60 afterwards.
- Fill TX with TX_DEPTH writes, out_ready=0 → next THR write gets bus_ack=0. Raise out_ready one cycle → write acks the following cycle. Order is preserved.
- Drive in_char 0x10..0x1F (16 bytes), IER=0x01 → in_ready=0 after 16 bytes. LSR=0x61. IIR=0x04. irq=1.
  - 16 RBR reads return 0x10..0x1F. Then DR=0, irq=0.
- IER=0x02 with TX empty → IIR=0x02, irq=1. IIR read clears it → next IIR=0x01.
  - THR write then drain → thre_pending re-asserts.
- LCR=0x80, write addr 0 =0x55 → no out_valid, DLL reads 0x55. LCR=0x03 → addr 0 is THR again.
- FCR write 0x07 with both FIFOs non-empty → both empty the next cycle. IIR[7:6]=11.
